// File: rtl/fft_bin_serializer.sv
// Captures one parallel FFT frame and streams its bins out one per handshake as unsigned magnitudes.
// Optional macro FFT_SER_POWER_EN switches the magnitude from |re|+|im| to re*re+im*im.
module fft_bin_serializer #(
    parameter int N    = 256,
    parameter int W    = 16,
    parameter int OW   = W + $clog2(N),
    parameter int HALF = 1,
    localparam int IW  = $clog2(N),
`ifdef FFT_SER_POWER_EN
    localparam int MW  = 2 * OW
`else
    localparam int MW  = OW + 1
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0][1:0][OW-1:0]    X,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    output logic                         bin_valid,
    input  logic                         bin_ready,
    output logic [IW-1:0]                bin_idx,
    output logic [MW-1:0]                bin_mag,
    output logic                         bin_last
);

    localparam logic [IW-1:0] LAST = (HALF != 0) ? IW'(N / 2) : IW'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                      state, state_nxt;
    logic [N-1:0][1:0][OW-1:0]   bank;
    logic                        capture, advance;
    logic [IW-1:0]               load_idx;
    logic [OW-1:0]               load_re, load_im;

    function automatic logic [MW-1:0] mag_of(input logic [OW-1:0] re, input logic [OW-1:0] im);
`ifdef FFT_SER_POWER_EN
        logic signed [2*OW-1:0] rx, ix, pr, pi;
        rx = {{OW{re[OW-1]}}, re};
        ix = {{OW{im[OW-1]}}, im};
        pr = rx * rx;
        pi = ix * ix;
        // Both squares are non-negative; their sum peaks at 2^(2*OW-1).
        return $unsigned(pr) + $unsigned(pi);
`else
        logic [OW-1:0] ar, ai;
        // Negating the most negative value yields 2^(OW-1), which is still exact as unsigned.
        ar = re[OW-1] ? -re : re;
        ai = im[OW-1] ? -im : im;
        return {1'b0, ar} + {1'b0, ai};
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_valid) state_nxt = STREAM;
            STREAM:  if (bin_ready && bin_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_ready = (state == IDLE);
        bin_valid   = (state == STREAM);
    end

    assign capture = frame_ready && frame_valid;
    assign advance = bin_valid && bin_ready && !bin_last;

    // Bin 0 comes straight from X so it is on the bus the cycle after capture.
    always_comb begin
        load_idx = capture ? '0 : bin_idx + IW'(1);
        load_re  = capture ? X[0][0] : bank[load_idx][0];
        load_im  = capture ? X[0][1] : bank[load_idx][1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank     <= '0;
            bin_idx  <= '0;
            bin_mag  <= '0;
            bin_last <= 1'b0;
        end else begin
            if (capture) bank <= X;
            if (capture || advance) begin
                bin_idx  <= load_idx;
                bin_mag  <= mag_of(load_re, load_im);
                bin_last <= (load_idx == LAST);
            end
        end
    end

endmodule
